// File: rtl/cgra_cfg_pkg.sv
// -----------------------------------------------------------------------------
// cgra_cfg_pkg
// Shared definitions for the CGRA configuration loader:
//   - default instruction width, context depth and length-field width
//   - PE instruction field widths and a packed view of one instruction word
//   - loader FSM state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package cgra_cfg_pkg;

    // Default sizing of the loader and of the PE context buffers.
    localparam int INST_W    = 48;
    localparam int CTX_DEPTH = 32;
    localparam int LEN_W     = 6;   // must be able to hold CTX_DEPTH itself

    // Instruction word fields, MSB first.
    localparam int FU_W      = 5;   // fu_opcode
    localparam int SW9X7_W   = 27;  // switch_9x7: 9 outputs x 3-bit select
    localparam int SW5X4_W   = 10;  // switch_5x4: 5 outputs x 2-bit select
    localparam int REG_SEL_W = 6;   // reg_file_sel

    typedef struct packed {
        logic [FU_W-1:0]      fu_opcode;
        logic [SW9X7_W-1:0]   switch_9x7;
        logic [SW5X4_W-1:0]   switch_5x4;
        logic [REG_SEL_W-1:0] reg_file_sel;
    } pe_inst_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } loader_state_t;

endpackage

// File: rtl/cgra_config_loader_if.sv
// -----------------------------------------------------------------------------
// cgra_config_loader_if
// Valid/ready instruction stream feeding the configuration loader.
//   s_valid  source -> loader   word valid
//   s_ready  loader -> source   loader accepts word
//   s_data   source -> loader   instruction word (DATA_W bits)
// Modports: master (stream source), slave (loader).
// -----------------------------------------------------------------------------
interface cgra_config_loader_if #(
    parameter int DATA_W = cgra_cfg_pkg::INST_W
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/pe_sel_decoder.sv
// -----------------------------------------------------------------------------
// pe_sel_decoder
// Converts a PE index into a one-hot PE select, all-zero when not enabled.
//   idx  in   IDX_W   PE index, 0..NUM_PE-1
//   we   in   1       write enable; gates the whole output
//   sel  out  NUM_PE  one-hot select (zero when we=0)
// -----------------------------------------------------------------------------
module pe_sel_decoder #(
    parameter int NUM_PE = 16,
    parameter int IDX_W  = 4
) (
    input  logic [IDX_W-1:0]  idx,
    input  logic              we,
    output logic [NUM_PE-1:0] sel
);

    // NOTE: the output gets a default before any conditional write so that
    // every path assigns it; otherwise synthesis infers a latch.
    always_comb begin
        sel = '0;
        if (we) begin
            sel[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/cgra_config_loader.sv
// -----------------------------------------------------------------------------
// cgra_config_loader
// Upstream sequencer for the PE array: clears the PEs, streams NUM_PE*ctx_len
// instruction words into the PE context buffers in PE order, then strobes the
// broadcast run signal for run_len cycles and pulses done.
//
// Ports:
//   clk            in   1        clock
//   rst            in   1        asynchronous active-low reset
//   cmd_start      in   1        start request, sampled only in IDLE
//   cmd_ctx_len    in   LEN_W    instructions per PE, legal 1..CTX_DEPTH
//   cmd_run_len    in   LEN_W    run cycles, legal 1..CTX_DEPTH
//   cmd_err        out  1        one-cycle pulse: illegal length at cmd_start
//   s_if           slave         valid/ready instruction stream
//   pe_rst         out  1        active-high synchronous clear to all PEs
//   pe_inst        out  INST_W   registered instruction broadcast
//   pe_init        out  NUM_PE   registered one-hot init enable
//   pe_run         out  1        registered broadcast run
//   busy           out  1        high whenever the FSM is not IDLE
//   done           out  1        one-cycle pulse after the last run cycle
//   perf_stall_cnt out  16       LOAD cycles with s_valid=0, saturating
//                                (only when CFG_LOADER_PERF_EN is defined)
//
// Build option: define CFG_LOADER_PERF_EN to add the stall counter.
// -----------------------------------------------------------------------------
module cgra_config_loader
    import cgra_cfg_pkg::*;
#(
    parameter int INST_W    = cgra_cfg_pkg::INST_W,
    parameter int NUM_PE    = 16,
    parameter int CTX_DEPTH = cgra_cfg_pkg::CTX_DEPTH,
    parameter int LEN_W     = cgra_cfg_pkg::LEN_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_start,
    input  logic [LEN_W-1:0]     cmd_ctx_len,
    input  logic [LEN_W-1:0]     cmd_run_len,
    output logic                 cmd_err,
    cgra_config_loader_if.slave  s_if,
    output logic                 pe_rst,
    output logic [INST_W-1:0]    pe_inst,
    output logic [NUM_PE-1:0]    pe_init,
    output logic                 pe_run,
    output logic                 busy,
    output logic                 done
`ifdef CFG_LOADER_PERF_EN
    ,
    output logic [15:0]          perf_stall_cnt
`endif
);

    localparam int              IDX_W   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(CTX_DEPTH);
    localparam logic [IDX_W-1:0] LAST_PE = IDX_W'(NUM_PE - 1);

    loader_state_t    state, state_next;

    logic [LEN_W-1:0] ctx_len_q;
    logic [LEN_W-1:0] run_len_q;
    logic [LEN_W-1:0] word_cnt;
    logic [LEN_W-1:0] run_cnt;
    logic [IDX_W-1:0] pe_idx;
    logic             fresh;     // no load has started since reset

    logic             hs;
    logic             cmd_ok;
    logic             start_ok;
    logic             last_word;
    logic             last_run;
    logic [NUM_PE-1:0] init_sel;

    assign cmd_ok    = (cmd_ctx_len != '0) && (cmd_ctx_len <= LEN_MAX) &&
                       (cmd_run_len != '0) && (cmd_run_len <= LEN_MAX);
    assign start_ok  = (state == S_IDLE) && cmd_start && cmd_ok;

    assign s_if.s_ready = (state == S_LOAD);
    assign hs           = s_if.s_valid && s_if.s_ready;

    assign last_word = (word_cnt == ctx_len_q - 1'b1);
    assign last_run  = (run_cnt == run_len_q - 1'b1);

    assign busy   = (state != S_IDLE);
    // The PEs stay cleared from reset until the first accepted command, and
    // are cleared again for one cycle at the start of every load.
    assign pe_rst = (state == S_CLEAR) || ((state == S_IDLE) && fresh);

    pe_sel_decoder #(
        .NUM_PE (NUM_PE),
        .IDX_W  (IDX_W)
    ) u_pe_sel (
        .idx (pe_idx),
        .we  (hs),
        .sel (init_sel)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (start_ok) state_next = S_CLEAR;
            S_CLEAR: state_next = S_LOAD;
            S_LOAD:  if (hs && last_word && (pe_idx == LAST_PE)) state_next = S_RUN;
            S_RUN:   if (last_run) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctx_len_q <= '0;
            run_len_q <= '0;
            word_cnt  <= '0;
            run_cnt   <= '0;
            pe_idx    <= '0;
            fresh     <= 1'b1;
            cmd_err   <= 1'b0;
            pe_inst   <= '0;
            pe_init   <= '0;
            pe_run    <= 1'b0;
            done      <= 1'b0;
        end else begin
            cmd_err <= (state == S_IDLE) && cmd_start && !cmd_ok;

            if (start_ok) begin
                ctx_len_q <= cmd_ctx_len;
                run_len_q <= cmd_run_len;
                fresh     <= 1'b0;
            end

            if (state == S_CLEAR) begin
                word_cnt <= '0;
                pe_idx   <= '0;
                run_cnt  <= '0;
            end

            if (hs) begin
                pe_inst <= s_if.s_data;
                if (last_word) begin
                    word_cnt <= '0;
                    pe_idx   <= pe_idx + 1'b1;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end

            if (state == S_RUN) begin
                run_cnt <= run_cnt + 1'b1;
            end

            // Registered strobes lag the FSM by one cycle, so pe_run starts
            // the cycle after the final pe_init pulse and done follows the
            // last pe_run cycle.
            pe_init <= init_sel;
            pe_run  <= (state == S_RUN);
            done    <= (state == S_DONE);
        end
    end

`ifdef CFG_LOADER_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
        end else if (state == S_CLEAR) begin
            perf_stall_cnt <= '0;
        end else if ((state == S_LOAD) && !s_if.s_valid &&
                     (perf_stall_cnt != 16'hFFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cgra_config_loader.sv
// -----------------------------------------------------------------------------
// tb_cgra_config_loader
// Self-checking bench for cgra_config_loader with NUM_PE=4. Commands come
// from a table of directed vectors; each legal command is traced cycle by
// cycle against the expected PE-order word sequence, run window and done
// timing. Hand-written sequences cover reset state and a mid-LOAD reset.
// -----------------------------------------------------------------------------
module tb_cgra_config_loader;
    import cgra_cfg_pkg::*;

    localparam int NPE = 4;
    localparam int IW  = 48;
    localparam int LW  = 6;

    logic            clk;
    logic            rst;
    logic            cmd_start;
    logic [LW-1:0]   cmd_ctx_len;
    logic [LW-1:0]   cmd_run_len;
    logic            cmd_err;
    logic            pe_rst;
    logic [IW-1:0]   pe_inst;
    logic [NPE-1:0]  pe_init;
    logic            pe_run;
    logic            busy;
    logic            done;
`ifdef CFG_LOADER_PERF_EN
    logic [15:0]     perf_stall_cnt;
`endif

    cgra_config_loader_if #(.DATA_W(IW)) s_if ();

    cgra_config_loader #(
        .INST_W    (IW),
        .NUM_PE    (NPE),
        .CTX_DEPTH (32),
        .LEN_W     (LW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_start   (cmd_start),
        .cmd_ctx_len (cmd_ctx_len),
        .cmd_run_len (cmd_run_len),
        .cmd_err     (cmd_err),
        .s_if        (s_if.slave),
        .pe_rst      (pe_rst),
        .pe_inst     (pe_inst),
        .pe_init     (pe_init),
        .pe_run      (pe_run),
        .busy        (busy),
        .done        (done)
`ifdef CFG_LOADER_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NPE-1:0] exp_onehot(input int k, input int ctx);
        logic [NPE-1:0] v;
        v = '0;
        v[k / ctx] = 1'b1;
        return v;
    endfunction

    typedef struct {
        logic [LW-1:0] ctx_len;
        logic [LW-1:0] run_len;
        bit            toggle;     // s_valid alternates 1,0,1,0 during LOAD
        bit            mid_start;  // pulse cmd_start during RUN
        bit            exp_err;
        logic [IW-1:0] base;       // first word value; words are base+k
        int            exp_stall;
    } vec_t;

    vec_t vecs[8];

    // One command: issue cmd_start, stream words, trace outputs until done.
    task automatic run_cmd(input vec_t v, input int id);
        int total, sent, rcv, order_err, extra_init, rst_cycles;
        int run_cycles, first_run, last_run, last_init, done_cnt, done_cycle;
        int ready_idx, busy_after, bad, budget;
        bit started_mid;
        string tag;
        tag = $sformatf("v%0d", id);

        @(negedge clk);
        cmd_ctx_len = v.ctx_len;
        cmd_run_len = v.run_len;
        cmd_start   = 1'b1;
        @(negedge clk);
        cmd_start   = 1'b0;

        if (v.exp_err) begin
            check({tag, "_cmd_err"}, 64'(cmd_err), 64'd1);
            check({tag, "_err_busy"}, 64'(busy), 64'd0);
            bad = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (cmd_err || busy || pe_run || (pe_init != '0) || s_if.s_ready) bad++;
            end
            check({tag, "_err_quiet"}, 64'(bad), 64'd0);
            return;
        end

        check({tag, "_no_cmd_err"}, 64'(cmd_err), 64'd0);
        total = int'(v.ctx_len) * NPE;
        budget = 2 * total + int'(v.run_len) + 30;
        sent = 0; rcv = 0; order_err = 0; extra_init = 0; rst_cycles = 0;
        run_cycles = 0; first_run = -1; last_run = -1; last_init = -1;
        done_cnt = 0; done_cycle = -1; ready_idx = 0; busy_after = 0;
        started_mid = 0;

        for (int cyc = 0; cyc < budget; cyc++) begin
            if (pe_rst) rst_cycles++;
            if (pe_init != '0) begin
                if (rcv >= total) extra_init++;
                else if (pe_init !== exp_onehot(rcv, int'(v.ctx_len)) ||
                         pe_inst !== v.base + IW'(rcv)) order_err++;
                rcv++;
                last_init = cyc;
            end
            if (pe_run) begin
                if (run_cycles == 0) first_run = cyc;
                last_run = cyc;
                run_cycles++;
            end
            if (done) begin
                done_cnt++;
                done_cycle = cyc;
            end else if (done_cnt > 0 && busy) begin
                busy_after++;
            end
            if (done_cnt > 0 && cyc >= done_cycle + 3) break;

            cmd_start = 1'b0;
            if (v.mid_start && run_cycles == 1 && !started_mid) begin
                cmd_start   = 1'b1;
                started_mid = 1'b1;
            end
            if (s_if.s_ready) begin
                s_if.s_valid = (v.toggle ? (ready_idx % 2 == 0) : 1'b1) && (sent < total);
                s_if.s_data  = v.base + IW'(sent);
                ready_idx++;
                if (s_if.s_valid) sent++;
            end else begin
                // After the load, keep offering junk words that must be refused.
                s_if.s_valid = (sent >= total);
                s_if.s_data  = 48'hBAD0_0000_0000 + IW'(sent);
            end
            @(negedge clk);
        end
        s_if.s_valid = 1'b0;
        cmd_start    = 1'b0;

        check({tag, "_pe_rst_cycles"}, 64'(rst_cycles), 64'd1);
        check({tag, "_words_loaded"}, 64'(rcv), 64'(total));
        check({tag, "_order_err"}, 64'(order_err), 64'd0);
        check({tag, "_extra_init"}, 64'(extra_init), 64'd0);
        check({tag, "_run_cycles"}, 64'(run_cycles), 64'(v.run_len));
        check({tag, "_run_contig"}, 64'(last_run - first_run + 1), 64'(v.run_len));
        check({tag, "_run_after_init"}, 64'(first_run), 64'(last_init + 1));
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check({tag, "_done_timing"}, 64'(done_cycle), 64'(last_run + 1));
        check({tag, "_busy_after"}, 64'(busy_after + int'(busy)), 64'd0);
`ifdef CFG_LOADER_PERF_EN
        check({tag, "_stall_cnt"}, 64'(perf_stall_cnt), 64'(v.exp_stall));
`endif
    endtask

    initial begin
        int sent;

        //            ctx    run    tog mid err base            stall
        vecs[0] = '{6'd2,  6'd3,  0, 0, 0, 48'h1,           0};
        vecs[1] = '{6'd2,  6'd3,  1, 0, 0, 48'h1,           7};
        vecs[2] = '{6'd0,  6'd3,  0, 0, 1, 48'h0,           0};
        vecs[3] = '{6'd33, 6'd3,  0, 0, 1, 48'h0,           0};
        vecs[4] = '{6'd2,  6'd0,  0, 0, 1, 48'h0,           0};
        vecs[5] = '{6'd32, 6'd32, 0, 0, 0, 48'h1000,        0};
        vecs[6] = '{6'd2,  6'd3,  0, 1, 0, 48'hA5A5_0000_0040, 0};
        vecs[7] = '{6'd1,  6'd1,  1, 0, 0, 48'h50,          3};

        rst          = 1'b0;
        cmd_start    = 1'b0;
        cmd_ctx_len  = '0;
        cmd_run_len  = '0;
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;

        // Reset state.
        #12;
        check("reset_pe_rst", 64'(pe_rst), 64'd1);
        check("reset_outputs", {pe_inst, pe_init, pe_run, busy, done, cmd_err, s_if.s_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_pe_rst_held", 64'(pe_rst), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i], i);
        end

        // Reset mid-LOAD after 5 words, then a fresh load from PE 0 word 0.
        @(negedge clk);
        cmd_ctx_len = 6'd2;
        cmd_run_len = 6'd3;
        cmd_start   = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        sent = 0;
        for (int i = 0; i < 40 && sent < 5; i++) begin
            if (s_if.s_ready) begin
                s_if.s_valid = 1'b1;
                s_if.s_data  = 48'h20 + IW'(sent);
                sent++;
            end else begin
                s_if.s_valid = 1'b0;
            end
            @(negedge clk);
        end
        s_if.s_valid = 1'b0;
        check("midload_pre_init", 64'(pe_init), 64'b0100);
        check("midload_pre_inst", 64'(pe_inst), 64'h24);
        #2 rst = 1'b0;
        #1;
        check("midload_rst_pe_rst", 64'(pe_rst), 64'd1);
        check("midload_rst_outputs", {pe_inst, pe_init, pe_run, busy, done, cmd_err, s_if.s_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_cmd('{6'd2, 6'd3, 0, 0, 0, 48'h30, 0}, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound in case something stalls outside the cycle budgets.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cgra_config_loader.md
Name: cgra_config_loader

Overview:
- Upstream sequencer for the PE array.
- Accepts a valid/ready stream of PE instruction words and writes them, in PE order, into each PE's 32-entry context buffer using the PE `init` input.
- Then drives the broadcast `run` strobe for a programmed number of cycles.
- Issues a one-cycle synchronous clear (`pe_rst`) before every load, because a PE's init write pointer is cleared only by its own reset.

Parameters:
- INST_W, 48, width of one PE instruction word (fu_opcode/switch_9x7/switch_5x4/reg_file_sel).
- NUM_PE, 16, number of PEs served; PE index 0..NUM_PE-1.
- CTX_DEPTH, 32, context buffer depth per PE; maximum instructions per PE and maximum run length.
- LEN_W, 6, width of length fields; must hold CTX_DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- cmd_start  in  1  one-cycle request to begin clear/load/run; sampled only in IDLE.
- cmd_ctx_len  in  LEN_W  instructions per PE, legal 1..CTX_DEPTH.
- cmd_run_len  in  LEN_W  run cycles, legal 1..CTX_DEPTH.
- cmd_err  out  1  one-cycle pulse: illegal length at cmd_start.
- s_valid  in  1  instruction word valid.
- s_ready  out  1  loader accepts word.
- s_data  in  INST_W  instruction word.
- pe_rst  out  1  active-high synchronous clear to all PEs.
- pe_inst  out  INST_W  registered instruction broadcast.
- pe_init  out  NUM_PE  registered one-hot init enable.
- pe_run  out  1  registered broadcast run.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last run cycle.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; all counters 0.
  - pe_rst=1; all other outputs 0.
  - While in IDLE after reset, pe_rst stays 1 until the first cmd_start; PEs remain cleared.
- States: IDLE, CLEAR, LOAD, RUN, DONE.
- IDLE:
  - cmd_start with both lengths legal: latch lengths, go to CLEAR.
  - cmd_start with either length 0 or >CTX_DEPTH: pulse cmd_err next cycle, stay IDLE, no PE activity.
- CLEAR:
  - Exactly one cycle with pe_rst=1; go to LOAD.
  - In every state except CLEAR and post-reset IDLE, pe_rst=0.
- LOAD:
  - s_ready=1, combinational from state.
  - On a handshake (s_valid & s_ready) in cycle t, in cycle t+1: pe_inst=s_data and pe_init is one-hot at the current pe_idx.
  - With no handshake, pe_init=0 next cycle; pe_inst holds its last value.
  - word_cnt increments per handshake. At word_cnt==ctx_len-1 the counter wraps to 0 and pe_idx increments.
  - Handshake of the last word of PE NUM_PE-1: deassert s_ready from the next cycle and go to RUN.
  - Words arriving after that are not accepted.
- RUN:
  - Entered the cycle after the final pe_init pulse.
  - pe_run=1 for exactly run_len consecutive cycles, then go to DONE.
  - pe_init=0 throughout.
- DONE: done=1 for one cycle; return to IDLE. pe_rst stays 0, so contexts are preserved until the next cmd_start.
- cmd_start is ignored while busy.
- An asynchronous reset mid-LOAD or mid-RUN aborts immediately. The partial load is discarded by the pe_rst=1 asserted in reset.
- Total accepted words per command = NUM_PE*ctx_len exactly.

Optional Feature:
- Macro CFG_LOADER_PERF_EN.
- Defined:
  - Adds output perf_stall_cnt[15:0], counting LOAD cycles with s_valid=0.
  - Saturates at 16'hFFFF.
  - Cleared in CLEAR and by reset; held outside LOAD.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package cgra_cfg_pkg holds:
  - INST_W, CTX_DEPTH and LEN_W constants.
  - Instruction field widths (FU, PE_9x7, PE_5x4, reg-select).
  - The loader state enum.
- One natural sub-module, pe_sel_decoder: pe_idx to NUM_PE one-hot, gated by a write-enable input.

Test Plan:
- Reset then cmd_start, ctx_len=2, run_len=3, NUM_PE=4, stream 8 words 0x1..0x8 with s_valid constant -> pe_rst for 1 cycle; pe_init sequence 0001,0001,0010,0010,0100,0100,1000,1000 with pe_inst 0x1..0x8; pe_run high 3 cycles; done 1 cycle; busy low after.
- Same command with s_valid toggling 1,0,1,0 -> identical init/inst order with pe_init=0 gaps; perf_stall_cnt=7 when CFG_LOADER_PERF_EN is defined.
- cmd_start with ctx_len=0, then with ctx_len=33 -> cmd_err pulse each time; busy stays 0; pe_init/pe_run stay 0.
- ctx_len=32, run_len=32 -> 32 words per PE; pe_run high exactly 32 cycles.
- rst low for 1 cycle mid-LOAD after 5 words -> all outputs immediately reset; pe_rst=1; a new cmd_start reloads from PE 0, word 0.
- cmd_start pulsed during RUN -> ignored; run length and done timing unchanged.
